// File: rtl/sprite_animator.sv
// Animation sequencer for player/enemy sprites: divides frame_clk to an animation rate and
// steps idle/run/jump cycles per facing. Define SPRITE_ANIM_SHOOT_EN to compile in the shoot pose.
module sprite_animator #(
    parameter int         RUN_FRAMES  = 5,
    parameter int         JUMP_FRAMES = 4,
    parameter int         FRAME_DIV   = 10,
    parameter logic [7:0] KEY_RIGHT   = 8'd7,
    parameter logic [7:0] KEY_LEFT    = 8'd4,
`ifdef SPRITE_ANIM_SHOOT_EN
    localparam int        NUM_SPRITES = 4 + 2*RUN_FRAMES + 2*JUMP_FRAMES,
`else
    localparam int        NUM_SPRITES = 2 + 2*RUN_FRAMES + 2*JUMP_FRAMES,
`endif
    localparam int        IDX_W       = $clog2(NUM_SPRITES)
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic [7:0]             keycode,
    input  logic                   direction,
    input  logic                   jumping,
    input  logic                   shooting,
    input  logic                   freeze,
    output logic [IDX_W-1:0]       sprite_idx,
    output logic [NUM_SPRITES-1:0] psprite,
    output logic                   facing,
    output logic                   cycle_done
);

    localparam int FMAX   = (RUN_FRAMES > JUMP_FRAMES) ? RUN_FRAMES : JUMP_FRAMES;
    localparam int FIDX_W = $clog2(FMAX);
    localparam int DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [FIDX_W-1:0] RUN_LAST  = FIDX_W'(RUN_FRAMES - 1);
    localparam logic [FIDX_W-1:0] JUMP_LAST = FIDX_W'(JUMP_FRAMES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FRAME_DIV - 1);

    localparam int RUN_R_BASE  = 2;
    localparam int RUN_L_BASE  = 2 + RUN_FRAMES;
    localparam int JUMP_R_BASE = 2 + 2*RUN_FRAMES;
    localparam int JUMP_L_BASE = 2 + 2*RUN_FRAMES + JUMP_FRAMES;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_RUN   = 2'd1;
    localparam logic [1:0] MODE_JUMP  = 2'd2;
`ifdef SPRITE_ANIM_SHOOT_EN
    localparam logic [1:0] MODE_SHOOT = 2'd3;
    localparam int         SHOOT_R    = NUM_SPRITES - 2;
`else
    // Shoot pose compiled out: the fire input has no effect.
    logic unused_shooting;
    assign unused_shooting = shooting;
`endif

    logic [1:0]        mode_q, mode_d;
    logic              facing_q, facing_d;
    logic [FIDX_W-1:0] fidx_q, fidx_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              cycle_done_q, cycle_done_d;
    logic              tick;
    logic              run_face;
    logic [IDX_W-1:0]  idx_dec;

    assign run_face = (keycode == KEY_RIGHT);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        tick         = (div_q == DIV_LAST) && !freeze;
        div_d        = div_q;
        mode_d       = mode_q;
        facing_d     = facing_q;
        fidx_d       = fidx_q;
        cycle_done_d = 1'b0;

        if (!freeze) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        if (tick) begin
            if (jumping) begin
                facing_d = direction;
                if (mode_q == MODE_JUMP && facing_q == direction) begin
                    if (fidx_q == JUMP_LAST) begin
                        fidx_d       = '0;
                        cycle_done_d = 1'b1;
                    end else begin
                        fidx_d = fidx_q + 1'b1;
                    end
                end else begin
                    mode_d = MODE_JUMP;
                    fidx_d = '0;
                end
            end else if (keycode == KEY_RIGHT || keycode == KEY_LEFT) begin
                facing_d = run_face;
                if (mode_q == MODE_RUN && facing_q == run_face) begin
                    if (fidx_q == RUN_LAST) begin
                        fidx_d       = '0;
                        cycle_done_d = 1'b1;
                    end else begin
                        fidx_d = fidx_q + 1'b1;
                    end
                end else begin
                    mode_d = MODE_RUN;
                    fidx_d = '0;
                end
`ifdef SPRITE_ANIM_SHOOT_EN
            end else if (shooting) begin
                mode_d   = MODE_SHOOT;
                facing_d = direction;
                fidx_d   = '0;
`endif
            end else begin
                mode_d   = MODE_IDLE;
                facing_d = direction;
                fidx_d   = '0;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            mode_q       <= MODE_IDLE;
            facing_q     <= 1'b1;
            fidx_q       <= '0;
            div_q        <= '0;
            cycle_done_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            facing_q     <= facing_d;
            fidx_q       <= fidx_d;
            div_q        <= div_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    // Out-of-range frame indices (unreachable) fall back to sprite 0 so psprite stays one-hot.
    always_comb begin
        idx_dec = '0;
        case (mode_q)
            MODE_IDLE: idx_dec = facing_q ? IDX_W'(0) : IDX_W'(1);
            MODE_RUN: begin
                if (fidx_q <= RUN_LAST) begin
                    idx_dec = (facing_q ? IDX_W'(RUN_R_BASE) : IDX_W'(RUN_L_BASE)) + IDX_W'(fidx_q);
                end
            end
            MODE_JUMP: begin
                if (fidx_q <= JUMP_LAST) begin
                    idx_dec = (facing_q ? IDX_W'(JUMP_R_BASE) : IDX_W'(JUMP_L_BASE)) + IDX_W'(fidx_q);
                end
            end
`ifdef SPRITE_ANIM_SHOOT_EN
            MODE_SHOOT: idx_dec = facing_q ? IDX_W'(SHOOT_R) : IDX_W'(SHOOT_R + 1);
`endif
            default: idx_dec = '0;
        endcase
    end

    assign sprite_idx = idx_dec;
    assign psprite    = {{(NUM_SPRITES-1){1'b0}}, 1'b1} << idx_dec;
    assign facing     = facing_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Scoreboard bench for sprite_animator: a behavioural model pushes expected outputs per tick,
// popped and compared at the tick edge; a second FRAME_DIV=1 instance covers the fast boundary.
module tb_sprite_animator;

`ifdef SPRITE_ANIM_SHOOT_EN
    localparam bit SHOOT_EN = 1'b1;
`else
    localparam bit SHOOT_EN = 1'b0;
`endif
    localparam int RF      = 5;
    localparam int JF      = 4;
    localparam int DIV     = 10;
    localparam int NS      = 2 + 2*RF + 2*JF + (SHOOT_EN ? 2 : 0);
    localparam int IW      = $clog2(NS);
    localparam int FAST_NS = 2 + 2*2 + 2*2 + (SHOOT_EN ? 2 : 0);
    localparam int FAST_IW = $clog2(FAST_NS);

    typedef struct {
        int idx;
        bit face;
        bit cd;
    } exp_t;

    logic               frame_clk = 1'b0;
    logic               Reset;
    logic [7:0]         keycode;
    logic               direction, jumping, shooting, freeze;
    logic [IW-1:0]      sprite_idx;
    logic [NS-1:0]      psprite;
    logic               facing, cycle_done;
    logic [FAST_IW-1:0] f_idx;
    logic [FAST_NS-1:0] f_psprite;
    logic               f_facing, f_cycle_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    int m_mode;  // 0 idle, 1 run, 2 jump, 3 shoot
    bit m_face;
    int m_fidx;

    sprite_animator #(.RUN_FRAMES(RF), .JUMP_FRAMES(JF), .FRAME_DIV(DIV)) u_dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .direction(direction),
        .jumping(jumping), .shooting(shooting), .freeze(freeze), .sprite_idx(sprite_idx),
        .psprite(psprite), .facing(facing), .cycle_done(cycle_done)
    );

    sprite_animator #(.RUN_FRAMES(2), .JUMP_FRAMES(2), .FRAME_DIV(1)) u_fast (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .direction(direction),
        .jumping(jumping), .shooting(shooting), .freeze(freeze), .sprite_idx(f_idx),
        .psprite(f_psprite), .facing(f_facing), .cycle_done(f_cycle_done)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_index();
        case (m_mode)
            0:       return m_face ? 0 : 1;
            1:       return (m_face ? 2 : 2 + RF) + m_fidx;
            2:       return (m_face ? 2 + 2*RF : 2 + 2*RF + JF) + m_fidx;
            default: return m_face ? NS - 2 : NS - 1;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_face = 1'b1;
        m_fidx = 0;
    endtask

    task automatic model_step(input logic [7:0] kc, input bit dir, input bit jmp, input bit sht,
                              output exp_t e);
        bit cd;
        bit f;
        cd = 1'b0;
        if (jmp) begin
            if (m_mode == 2 && m_face == dir) begin
                if (m_fidx == JF - 1) begin m_fidx = 0; cd = 1'b1; end
                else m_fidx++;
            end else begin
                m_mode = 2;
                m_fidx = 0;
            end
            m_face = dir;
        end else if (kc == 8'd7 || kc == 8'd4) begin
            f = (kc == 8'd7);
            if (m_mode == 1 && m_face == f) begin
                if (m_fidx == RF - 1) begin m_fidx = 0; cd = 1'b1; end
                else m_fidx++;
            end else begin
                m_mode = 1;
                m_fidx = 0;
            end
            m_face = f;
        end else if (SHOOT_EN && sht) begin
            m_mode = 3; m_face = dir; m_fidx = 0;
        end else begin
            m_mode = 0; m_face = dir; m_fidx = 0;
        end
        e.idx  = m_index();
        e.face = m_face;
        e.cd   = cd;
    endtask

    // One animation step: decoy inputs until the edge before the tick, then the real ones.
    task automatic do_tick(input logic [7:0] kc, input bit dir, input bit jmp, input bit sht,
                           input int freeze_at);
        exp_t e;
        int   prev_idx;
        prev_idx  = m_index();
        model_step(kc, dir, jmp, sht, e);
        exp_q.push_back(e);
        keycode   = (kc == 8'd7) ? 8'd4 : 8'd7;
        direction = ~dir;
        jumping   = ~jmp;
        shooting  = ~sht;
        for (int k = 1; k <= DIV; k++) begin
            @(posedge frame_clk);
            #1;
            if (k < DIV) begin
                if (k == 1 || k == DIV - 1) begin
                    check("hold_idx", sprite_idx, prev_idx);
                    check("cd_low", cycle_done, 0);
                end
                if (k == freeze_at) begin
                    freeze = 1'b1;
                    repeat (25) @(posedge frame_clk);
                    #1;
                    check("freeze_idx", sprite_idx, prev_idx);
                    freeze = 1'b0;
                end
                if (k == DIV - 1) begin
                    keycode = kc; direction = dir; jumping = jmp; shooting = sht;
                end
            end else if (exp_q.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("tick_idx", sprite_idx, e.idx);
                check("tick_onehot", psprite, 1 << e.idx);
                check("tick_facing", facing, e.face);
                check("tick_cd", cycle_done, e.cd);
            end
        end
    endtask

    initial begin
        int f_exp[$];
        Reset = 1'b1; keycode = 8'd0; direction = 1'b0; jumping = 1'b0;
        shooting = 1'b0; freeze = 1'b1;
        model_reset();
        repeat (2) @(posedge frame_clk);
        #1;
        check("rst_idx", sprite_idx, 0);
        check("rst_onehot", psprite, 1);
        check("rst_facing", facing, 1);
        check("rst_cd", cycle_done, 0);
        freeze = 1'b0;
        Reset  = 1'b0;

        do_tick(8'd0, 1'b0, 1'b0, 1'b0, -1);                      // idle left
        repeat (6) do_tick(8'd7, 1'b0, 1'b0, 1'b0, -1);           // 2..6,2 with wrap
        repeat (3) do_tick(8'd7, 1'b0, 1'b0, 1'b0, -1);           // to frame 3
        do_tick(8'd4, 1'b1, 1'b0, 1'b0, -1);                      // run left frame 0
        repeat (5) do_tick(8'd7, 1'b1, 1'b1, 1'b0, -1);           // jump 12..15,12
        do_tick(8'd7, 1'b0, 1'b1, 1'b0, -1);                      // facing flip restarts
        do_tick(8'h20, 1'b1, 1'b0, 1'b0, -1);                     // unknown key = idle
        do_tick(8'd7, 1'b0, 1'b0, 1'b0, 3);                       // freeze mid-step
        do_tick(8'd7, 1'b0, 1'b0, 1'b0, -1);
        do_tick(8'd0, 1'b0, 1'b0, 1'b1, -1);                      // shoot or idle
        repeat (5) do_tick(8'd7, 1'b0, 1'b0, 1'b1, -1);           // key beats shoot

        // Next tick would wrap the run; reset on that edge must win with no pulse.
        keycode = 8'd7; jumping = 1'b0;
        repeat (DIV - 1) @(posedge frame_clk);
        #1;
        Reset = 1'b1;
        @(posedge frame_clk);
        #1;
        check("midrst_idx", sprite_idx, 0);
        check("midrst_facing", facing, 1);
        check("midrst_cd", cycle_done, 0);
        @(posedge frame_clk);
        #1;
        check("midrst_cd2", cycle_done, 0);
        Reset = 1'b0;
        model_reset();
        do_tick(8'd4, 1'b1, 1'b0, 1'b0, -1);

        // FRAME_DIV=1 instance: a step on every unfrozen edge.
        Reset = 1'b1; keycode = 8'd7; direction = 1'b1; jumping = 1'b0; shooting = 1'b0;
        @(posedge frame_clk);
        #1;
        Reset = 1'b0;
        f_exp = '{2, 3, 2, 3};
        for (int k = 0; k < 4; k++) begin
            @(posedge frame_clk);
            #1;
            check("fast_idx", f_idx, f_exp.pop_front());
            check("fast_cd", f_cycle_done, (k == 2) ? 1 : 0);
        end
        freeze = 1'b1;
        @(posedge frame_clk);
        #1;
        check("fast_frz_idx", f_idx, 3);
        check("fast_frz_cd", f_cycle_done, 0);
        freeze = 1'b0;
        @(posedge frame_clk);
        #1;
        check("fast_resume", f_idx, 2);
        check("fast_resume_cd", f_cycle_done, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
